alu_share_arbiter: RTL and testbench

- Shares the single 32-bit ALU (ops ADD/SUB/AND32/OR32/XOR32/NOR32/SRL/SLL/ADDU/SUBU and compares BEQ/BNE/BLT/BGT/BGE/BLE) between two requesters.
- Performs round-robin arbitration with valid/ready handshakes and registers the operands that drive the ALU.
- Captures and sanitises the ALU outputs into a tagged response register.
- Sits between the issue logic and the ALU in the datapath.

---
 rtl/alu_share_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 32-bit ALU between two requesters.
// The block grants requesters round-robin over valid/ready handshakes and
// registers the operands that drive the ALU. One cycle later it captures the
// ALU outputs into a tagged response register, with the fields cleaned up
// according to the opcode class.
module alu_share_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_in1,
    output logic [W-1:0]   alu_in2,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_z,
    input  logic           alu_cout,
    input  logic           alu_of,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_z,
    output logic           rsp_cout,
    output logic           rsp_of,
    output logic           rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU opcode landmarks used by the sanitiser
    localparam logic [OPW-1:0] OP_ADD    = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_ADDU   = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_SUBU   = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_CMP_LO = OPW'(8'h10);
    localparam logic [OPW-1:0] OP_CMP_HI = OPW'(8'h15);

    // Arithmetic, logic and shift ops occupy 0x00..0x09
    function automatic logic is_arith(input logic [OPW-1:0] op);
        return (op <= OP_SUBU);
    endfunction

    // Compares occupy 0x10..0x15
    function automatic logic is_cmp(input logic [OPW-1:0] op);
        return (op >= OP_CMP_LO) && (op <= OP_CMP_HI);
    endfunction

    // Carry is only meaningful for add/subtract flavours
    function automatic logic has_cout(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDU) || (op == OP_SUBU);
    endfunction

    // Overflow is only meaningful for signed add/subtract
    function automatic logic has_of(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_last_grant;
    logic           r_pend_id;
    logic [OPW-1:0] r_alu_op;
    logic [W-1:0]   r_alu_in1;
    logic [W-1:0]   r_alu_in2;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_result;
    logic           r_rsp_z;
    logic           r_rsp_cout;
    logic           r_rsp_of;
    logic           r_rsp_err;

    logic           w_accept;
    logic           w_grant;
    logic           w_grant_id;
    logic [OPW-1:0] w_sel_op;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [W-1:0]   w_san_result;
    logic           w_san_z;
    logic           w_san_cout;
    logic           w_san_of;
    logic           w_san_err;

    // Accept window and round-robin grant selection; nothing is granted during reset
    always_comb begin
        w_accept   = 1'b0;
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        if (rst) begin
            w_accept = 1'b0;
        end else if (r_state == ST_IDLE) begin
            w_accept = 1'b1;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
        w_grant = w_accept && (req0_valid || req1_valid);
    end

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant && w_grant_id;
    assign w_sel_op   = w_grant_id ? req1_op : req0_op;
    assign w_sel_a    = w_grant_id ? req1_a  : req0_a;
    assign w_sel_b    = w_grant_id ? req1_b  : req0_b;

    // Next-state logic: EXEC always lasts one cycle, RESP waits for the consumer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_grant) begin
                    w_state_nxt = ST_EXEC;
                end else if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Clean up the raw ALU outputs; undefined opcodes ignore the (stale) ALU entirely
    always_comb begin
        w_san_result = '0;
        w_san_z      = 1'b0;
        w_san_cout   = 1'b0;
        w_san_of     = 1'b0;
        w_san_err    = 1'b0;
        if (is_arith(r_alu_op)) begin
            w_san_result = alu_result;
            w_san_cout   = has_cout(r_alu_op) ? alu_cout : 1'b0;
            w_san_of     = has_of(r_alu_op) ? alu_of : 1'b0;
        end else if (is_cmp(r_alu_op)) begin
            w_san_z = alu_z;
        end else begin
            w_san_err = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin memory and the id of the op currently in the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_pend_id    <= 1'b0;
        end else if (w_grant) begin
            r_last_grant <= w_grant_id;
            r_pend_id    <= w_grant_id;
        end
    end

    // ALU operand registers; they move only on a grant to keep the ALU inputs quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op  <= '0;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
        end else if (w_grant) begin
            r_alu_op  <= w_sel_op;
            r_alu_in1 <= w_sel_a;
            r_alu_in2 <= w_sel_b;
        end
    end

    // Response register: captured in EXEC, held in RESP until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_z      <= 1'b0;
            r_rsp_cout   <= 1'b0;
            r_rsp_of     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_pend_id;
            r_rsp_result <= w_san_result;
            r_rsp_z      <= w_san_z;
            r_rsp_cout   <= w_san_cout;
            r_rsp_of     <= w_san_of;
            r_rsp_err    <= w_san_err;
        end else if ((r_state == ST_RESP) && rsp_ready && !w_grant) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_z      = r_rsp_z;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_of     = r_rsp_of;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model (occupancy + response slot).
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_in1, alu_in2, alu_result;
    logic        alu_z, alu_cout, alu_of;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_cout, rsp_of, rsp_err;
    logic [31:0] rsp_result;
    logic [31:0] g;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one op in the ALU (m_busy) and one response slot (m_rv)
    logic        m_busy, m_id, m_last, m_rv, m_rid, m_z, m_c, m_o, m_e;
    logic [7:0]  m_op;
    logic [31:0] m_a, m_b, m_res;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } alu_out_t;

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(32), .OPW(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_z(alu_z), .alu_cout(alu_cout), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_cout(rsp_cout), .rsp_of(rsp_of), .rsp_err(rsp_err)
    );

    // Behavioural ALU; fields it does not define carry garbage from gg
    function automatic alu_out_t ref_alu(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] gg);
        alu_out_t   r;
        logic [32:0] s;
        r.res = gg; r.z = gg[0]; r.c = gg[1]; r.o = gg[2];
        case (op)
            8'h00, 8'h08: begin
                s = {1'b0, a} + {1'b0, b};
                r.res = s[31:0]; r.c = s[32];
                if (op == 8'h00) r.o = (a[31] == b[31]) && (s[31] != a[31]);
            end
            8'h01, 8'h09: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.res = s[31:0]; r.c = s[32];
                if (op == 8'h01) r.o = (a[31] != b[31]) && (s[31] != a[31]);
            end
            8'h02: r.res = a & b;
            8'h03: r.res = a | b;
            8'h04: r.res = a ^ b;
            8'h05: r.res = ~(a | b);
            8'h06: r.res = a >> b[4:0];
            8'h07: r.res = a << b[4:0];
            8'h10: r.z = (a == b);
            8'h11: r.z = (a != b);
            8'h12: r.z = ($signed(a) <  $signed(b));
            8'h13: r.z = ($signed(a) >  $signed(b));
            8'h14: r.z = ($signed(a) >= $signed(b));
            8'h15: r.z = ($signed(a) <= $signed(b));
            default: ;
        endcase
        return r;
    endfunction

    alu_out_t w_alu;
    always_comb begin
        w_alu      = ref_alu(alu_op, alu_in1, alu_in2, g);
        alu_result = w_alu.res;
        alu_z      = w_alu.z;
        alu_cout   = w_alu.c;
        alu_of     = w_alu.o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check readies, advance model, check registered outputs
    task automatic step(input logic r, input logic v0, input logic [7:0] o0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic v1, input logic [7:0] o1,
                        input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        logic     acc, gnt, gid;
        alu_out_t ao;
        @(negedge clk);
        rst = r; rsp_ready = rr; g = $urandom;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        #1;
        acc = !r && !m_busy && (!m_rv || rr);
        gnt = acc && (v0 || v1);
        gid = (v0 && v1) ? !m_last : v1;
        check("ready0", 32'(req0_ready), 32'(gnt && !gid));
        check("ready1", 32'(req1_ready), 32'(gnt && gid));
        check("one_ready", 32'(req0_ready && req1_ready), 32'd0);
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0; m_id = 1'b0; m_last = 1'b1; m_rv = 1'b0; m_rid = 1'b0;
            m_res = 32'd0; m_z = 1'b0; m_c = 1'b0; m_o = 1'b0; m_e = 1'b0;
            m_op = 8'd0; m_a = 32'd0; m_b = 32'd0;
        end else begin
            if (m_busy) begin
                ao = ref_alu(m_op, m_a, m_b, g);
                m_rv = 1'b1; m_rid = m_id;
                m_res = 32'd0; m_z = 1'b0; m_c = 1'b0; m_o = 1'b0; m_e = 1'b0;
                if (m_op <= 8'h09) begin
                    m_res = ao.res;
                    m_c = (m_op == 8'h00 || m_op == 8'h01 || m_op == 8'h08 || m_op == 8'h09) ? ao.c : 1'b0;
                    m_o = (m_op <= 8'h01) ? ao.o : 1'b0;
                end else if (m_op >= 8'h10 && m_op <= 8'h15) begin
                    m_z = ao.z;
                end else begin
                    m_e = 1'b1;
                end
            end else if (m_rv && rr && !gnt) begin
                m_rv = 1'b0;
            end
            if (gnt) begin
                m_id = gid; m_last = gid;
                m_op = gid ? o1 : o0; m_a = gid ? a1 : a0; m_b = gid ? b1 : b0;
            end
            m_busy = gnt;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(m_rid));
            check("rsp_result", rsp_result, m_res);
            check("rsp_z", 32'(rsp_z), 32'(m_z));
            check("rsp_cout", 32'(rsp_cout), 32'(m_c));
            check("rsp_of", 32'(rsp_of), 32'(m_o));
            check("rsp_err", 32'(rsp_err), 32'(m_e));
        end
        check("alu_op", 32'(alu_op), 32'(m_op));
        check("alu_in1", alu_in1, m_a);
        check("alu_in2", alu_in2, m_b);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0, 32'd0, rr);
    endtask

    task automatic r0(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr);
        step(1'b0, 1'b1, op, a, b, 1'b0, 8'd0, 32'd0, 32'd0, rr);
    endtask

    task automatic r1(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr);
        step(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b1, op, a, b, rr);
    endtask

    function automatic logic [7:0] pick_op();
        int unsigned k;
        k = $urandom_range(0, 17);
        if (k < 10) return 8'(k);
        else if (k < 16) return 8'(8'h10 + 8'(k - 10));
        else return 8'($urandom);
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 3))
            0: return 32'h7FFF_FFFF;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] saved;

    initial begin
        rst = 1'b1; rsp_ready = 1'b0; g = 32'd0;
        req0_valid = 1'b0; req0_op = 8'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 8'd0; req1_a = 32'd0; req1_b = 32'd0;
        m_busy = 1'b0; m_id = 1'b0; m_last = 1'b1; m_rv = 1'b0; m_rid = 1'b0;
        m_res = 32'd0; m_z = 1'b0; m_c = 1'b0; m_o = 1'b0; m_e = 1'b0;
        m_op = 8'd0; m_a = 32'd0; m_b = 32'd0;

        // Reset state: every output clear
        step(1'b1, 1'b1, 8'h00, 32'd1, 32'd1, 1'b1, 8'h00, 32'd1, 32'd1, 1'b1);
        step(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", 32'({rsp_id, rsp_z, rsp_cout, rsp_of, rsp_err}), 32'd0);

        // ADD 5+1 from requester 0, response two cycles after acceptance
        r0(8'h00, 32'd5, 32'd1, 1'b0);
        idle(1'b0);
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_id", 32'(rsp_id), 32'd0);
        check("add_res", rsp_result, 32'd6);
        check("add_flags", 32'({rsp_z, rsp_cout, rsp_of, rsp_err}), 32'd0);
        idle(1'b1);

        // Both requesters every cycle: alternating grants, one response per two cycles
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 8'h01, 32'd5, 32'd1, 1'b1, 8'h04, 32'd5, 32'd1, 1'b1);
        check("alt_res", rsp_result, 32'd4);
        idle(1'b1); idle(1'b1);

        // Overflow / carry corners
        r1(8'h00, 32'h7FFF_FFFF, 32'd1, 1'b0); idle(1'b0);
        check("ovf_res", rsp_result, 32'h8000_0000);
        check("ovf_of", 32'(rsp_of), 32'd1);
        check("ovf_id", 32'(rsp_id), 32'd1);
        r1(8'h08, 32'h7FFF_FFFF, 32'd1, 1'b1); idle(1'b0);
        check("addu_of", 32'(rsp_of), 32'd0);
        r1(8'h00, 32'hFFFF_FFFF, 32'd1, 1'b1); idle(1'b0);
        check("wrap_res", rsp_result, 32'd0);
        check("wrap_cout", 32'(rsp_cout), 32'd1);
        check("wrap_of", 32'(rsp_of), 32'd0);

        // Compare and illegal opcode
        r0(8'h12, 32'd1, 32'd5, 1'b1); idle(1'b0);
        check("blt_z", 32'(rsp_z), 32'd1);
        check("blt_res", rsp_result, 32'd0);
        r0(8'h2A, 32'd9, 32'd9, 1'b1); idle(1'b0);
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_rest", 32'({rsp_z, rsp_cout, rsp_of} | 3'(|rsp_result)), 32'd0);

        // Consumer stall: response held, no new acceptance until rsp_ready
        r0(8'h07, 32'd3, 32'd4, 1'b1); idle(1'b0);
        saved = rsp_result;
        for (int i = 0; i < 5; i++) begin
            r0(8'h03, 32'hA5, 32'h5A, 1'b0);
            check("stall_hold", rsp_result, saved);
        end
        r0(8'h03, 32'hA5, 32'h5A, 1'b1);
        check("stall_take", alu_in1, 32'hA5);

        // Reset while in EXEC, then requester 0 wins first contention
        step(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
        check("rstx_valid", 32'(rsp_valid), 32'd0);
        check("rstx_alu", alu_in1 | alu_in2 | 32'(alu_op), 32'd0);
        step(1'b0, 1'b1, 8'h02, 32'h11, 32'h0F, 1'b1, 8'h02, 32'h22, 32'h0F, 1'b0);
        check("rstx_win", alu_in1, 32'h11);
        idle(1'b0); idle(1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), pick_op(), pick_val(), pick_val(),
                 ($urandom_range(0, 2) != 0), pick_op(), pick_val(), pick_val(), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
